// File: rtl/commit_trace_buffer.sv
// Commit trace recorder: captures CPU commit records into a circular or fill-once
// buffer, stops on halt, and reads entries back by age through a field-select port.
module commit_trace_buffer #(
    parameter int unsigned AW           = 6,
    parameter int unsigned WRAP_MODE    = 1,
    parameter int unsigned STOP_ON_HALT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          global_en,
    input  logic          arm,
    input  logic          clear,
    input  logic          commit,
    input  logic [31:0]   commit_pc,
    input  logic [31:0]   commit_inst,
    input  logic          commit_halt,
    input  logic          commit_reg_we,
    input  logic [4:0]    commit_reg_wa,
    input  logic [31:0]   commit_reg_wd,
    input  logic          commit_dmem_we,
    input  logic [31:0]   commit_dmem_wa,
    input  logic [31:0]   commit_dmem_wd,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    input  logic [2:0]    rd_sel,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count,
    output logic [1:0]    state,
    output logic          overflow,
    output logic          halted,
    output logic [31:0]   total_commits
);

    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        halt;
        logic        reg_we;
        logic [4:0]  reg_wa;
        logic [31:0] reg_wd;
        logic        dmem_we;
        logic [31:0] dmem_wa;
        logic [31:0] dmem_wd;
        logic [31:0] seq;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        wr_entry;
    entry_t        rd_entry;

    state_e        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW:0]   count_q,    count_d;
    logic          overflow_q, overflow_d;
    logic          halted_q,   halted_d;
    logic [31:0]   total_q,    total_d;
    logic          rd_valid_q, rd_valid_d;
    logic [31:0]   rd_data_q,  rd_data_d;

    logic          accept;
    logic          wr_en;
    logic [AW-1:0] rd_base;
    logic [AW-1:0] rd_phys;
    logic [31:0]   rd_field;

    assign accept = (state_q == ST_CAPTURE) && commit && global_en;
    assign wr_en  = accept && !clear;

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = commit_pc;
        wr_entry.inst    = commit_inst;
        wr_entry.halt    = commit_halt;
        wr_entry.reg_we  = commit_reg_we;
        wr_entry.reg_wa  = commit_reg_wa;
        wr_entry.reg_wd  = commit_reg_wd;
        wr_entry.dmem_we = commit_dmem_we;
        wr_entry.dmem_wa = commit_dmem_wa;
        wr_entry.dmem_wd = commit_dmem_wd;
        wr_entry.seq     = total_q;
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        halted_d   = halted_q;
        total_d    = total_q;
        if (clear) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            halted_d   = 1'b0;
            total_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d    = ST_CAPTURE;
                        wr_ptr_d   = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        halted_d   = 1'b0;
                        total_d    = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        total_d  = (total_q == '1) ? total_q : total_q + 32'd1;
                        if (count_q != DEPTH_C) begin
                            count_d = count_q + (AW+1)'(1);
                        end else if (WRAP_MODE != 0) begin
                            overflow_d = 1'b1;
                        end
                        // Fill-once stops on the accept that fills the last slot.
                        if ((WRAP_MODE == 0) && (count_q == DEPTH_C - (AW+1)'(1))) begin
                            state_d = ST_DONE;
                        end
                        if (commit_halt) begin
                            halted_d = 1'b1;
                            if (STOP_ON_HALT != 0) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (arm) begin
                        state_d    = ST_CAPTURE;
                        wr_ptr_d   = '0;
                        count_d    = '0;
                        overflow_d = 1'b0;
                        halted_d   = 1'b0;
                        total_d    = '0;
                    end else if ((WRAP_MODE == 0) && commit && global_en) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Oldest entry sits at slot 0 until the buffer fills, then at wr_ptr.
    always_comb begin
        rd_base  = (count_q == DEPTH_C) ? wr_ptr_q : '0;
        rd_phys  = rd_base + rd_idx;
        rd_entry = mem_q[rd_phys];
        unique case (rd_sel)
            3'd0:    rd_field = rd_entry.pc;
            3'd1:    rd_field = rd_entry.inst;
            3'd2:    rd_field = {26'b0, rd_entry.reg_we, rd_entry.reg_wa};
            3'd3:    rd_field = rd_entry.reg_wd;
            3'd4:    rd_field = {29'b0, rd_entry.halt, rd_entry.dmem_we, rd_entry.reg_we};
            3'd5:    rd_field = rd_entry.dmem_wa;
            3'd6:    rd_field = rd_entry.dmem_wd;
            default: rd_field = rd_entry.seq;
        endcase
        rd_valid_d = rd_en;
        rd_data_d  = (rd_en && ({1'b0, rd_idx} < count_q)) ? rd_field : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halted_q   <= 1'b0;
            total_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halted_q   <= halted_d;
            total_q    <= total_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid      = rd_valid_q;
    assign rd_data       = rd_data_q;
    assign count         = count_q;
    assign state         = state_q;
    assign overflow      = overflow_q;
    assign halted        = halted_q;
    assign total_commits = total_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Synthesizable on-chip recorder for the CPU commit interface. It captures up to DEPTH commit records (pc, inst, register write-back, dmem write, halt) into a circular or fill-once buffer and stops on halt.
- Records are read back by index (oldest = 0) through a 32-bit field-select port.
- Sits beside the CPU at top level. The debug unit and benches use it to inspect the last N commits without a waveform dump.

Parameters:
- AW, 6, index width; DEPTH = 2**AW entries.
- WRAP_MODE, 1: 1 = circular (keep newest DEPTH), 0 = fill once then stop.
- STOP_ON_HALT, 1: 1 = enter DONE after recording a halt commit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (rst=0 resets)
- global_en  in  1  capture qualifier; commit ignored when 0
- arm  in  1  single-cycle pulse; IDLE->CAPTURE
- clear  in  1  synchronous flush to IDLE
- commit  in  1  commit valid
- commit_pc, commit_inst  in  32 each  committed pc / instruction
- commit_halt  in  1  halt commit
- commit_reg_we  in  1  / commit_reg_wa  in  5 / commit_reg_wd  in  32  register write
- commit_dmem_we  in  1 / commit_dmem_wa  in  32 / commit_dmem_wd  in  32  memory write
- rd_en  in  1  read request
- rd_idx  in  AW  entry index, 0 = oldest
- rd_sel  in  3  field select
- rd_valid  out  1  rd_data valid
- rd_data  out  32  selected field
- count  out  AW+1  valid entries (0..DEPTH)
- state  out  2  0 IDLE, 1 CAPTURE, 2 DONE
- overflow  out  1  sticky; a record was overwritten (WRAP) or dropped (fill)
- halted  out  1  sticky; a halt commit was recorded
- total_commits  out  32  accepted commits since arm, saturates at 0xFFFFFFFF

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_ptr=0, count=0, overflow=0, halted=0, total_commits=0, rd_valid=0, rd_data=0. Storage contents are not reset.
- Accept: accept = (state==CAPTURE) && commit && global_en. On accept, all fields are written to mem[wr_ptr]; wr_ptr increments mod DEPTH; total_commits increments (saturating).
- count increments on accept and saturates at DEPTH.
- Capture latency: a record accepted at edge N is readable by a rd_en issued at edge N+1.
- FSM, with clear (sync) taking priority over all transitions:
  - IDLE: arm -> CAPTURE. Arming clears wr_ptr, count, overflow, halted and total_commits in the same edge. No capture occurs in the arm cycle.
  - CAPTURE: accept of a halt commit with STOP_ON_HALT=1 -> DONE, halted=1. The halt record is stored.
  - CAPTURE, WRAP_MODE=0: the accept that makes count==DEPTH -> DONE.
  - CAPTURE, WRAP_MODE=1: an accept while count==DEPTH overwrites the oldest entry and sets overflow=1. State is unchanged.
  - DONE: commits are ignored. If WRAP_MODE=0 and a commit arrives with global_en=1, overflow=1. arm -> CAPTURE (re-arm with clear as above).
  - arm in CAPTURE is ignored.
  - clear: state=IDLE, count=0, wr_ptr=0, flags and total_commits cleared.
- Readout (1-cycle latency):
  - rd_en at edge N gives rd_valid=1 and rd_data from edge N until the next edge. rd_valid=0 when rd_en was low.
  - Reads are allowed in any state.
  - Physical index = (count<DEPTH ? 0 : wr_ptr) + rd_idx, mod DEPTH.
  - rd_idx >= count returns rd_data=0 with rd_valid=1.
  - A read and a write to the same slot in the same cycle returns the pre-write contents.
- rd_sel field map:
  - 0 pc
  - 1 inst
  - 2 {26'b0, reg_we, reg_wa}
  - 3 reg_wd
  - 4 {29'b0, halt, dmem_we, reg_we}
  - 5 dmem_wa
  - 6 dmem_wd
  - 7 {sequence number of entry, zero-extended}. The sequence number is the value of total_commits when the entry was accepted, so the first commit after arm has seq 0.
- Timing: no combinational path from commit inputs to any output. Storage is a plain register array or inferred RAM.

Test Plan:
- Basic capture: reset, arm, then 5 commits with pc=0x0,0x4,...,0x10 -> count=5, state=1. rd_idx=2, rd_sel=0 gives rd_data=0x8 one cycle after rd_en. rd_idx=7 gives 0.
- Wrap (AW=2): 6 commits with pc 0x00..0x14 -> count=4, overflow=1. rd_idx=0 returns pc 0x08 and rd_sel=7 returns 2. total_commits=6.
- Fill mode (AW=2, WRAP_MODE=0): 4 commits -> state=DONE. A 5th commit -> overflow=1, entry 3 unchanged, total_commits=4.
- Halt: a commit with commit_halt=1 as the 3rd record -> state=DONE, halted=1, count=3. A subsequent commit is ignored. rd_sel=4 on idx 2 gives bit2=1.
- Qualifiers: commit pulses with global_en=0 -> count stays 0. arm held during CAPTURE does not clear count. clear -> state=IDLE, count=0.
- Async reset mid-capture: drive rst=0 between clock edges after 3 commits -> all outputs read 0 immediately. After rst=1, commits are ignored until arm.
